// File: rtl/uart_par_engine.sv
// Serial parity engine: accumulates parity as UART data bits shift by, then either
// emits the parity bit (TX) or checks the received one and counts errors (RX).
module uart_par_engine #(
  parameter int MAX_WIDTH = 9,
  parameter int CNT_WIDTH = 8,
  parameter int LEN_WIDTH = 5
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 FRAME_START,
  input  logic                 DIR_RX,
  input  logic                 PAR_EN,
  input  logic [1:0]           PAR_MODE,
  input  logic [LEN_WIDTH-1:0] DATA_LEN,
  input  logic                 BIT_VALID,
  input  logic                 BIT_IN,
  input  logic                 CNT_CLR,
  output logic                 PAR_BIT,
  output logic                 PAR_RDY,
  output logic                 PAR_ERR,
  output logic                 FRAME_DONE,
  output logic                 BUSY,
  output logic [CNT_WIDTH-1:0] ERR_CNT
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, DONE} state_t;

  localparam logic [LEN_WIDTH-1:0] MIN_LEN = LEN_WIDTH'(5);
  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t               state_reg, state_next;
  logic                 acc_reg, acc_next;
  logic [LEN_WIDTH-1:0] cnt_reg, cnt_next;
  logic [LEN_WIDTH-1:0] len_reg, len_next;
  logic                 dir_rx_reg, dir_rx_next;
  logic                 par_en_reg, par_en_next;
  logic [1:0]           par_mode_reg, par_mode_next;
  logic                 par_bit_reg, par_bit_next;
  logic                 mis_reg, mis_next;
  logic [CNT_WIDTH-1:0] err_cnt_reg;
  logic [LEN_WIDTH-1:0] len_clamped;
  logic                 done;

  function automatic logic parity_of(input logic [1:0] mode, input logic acc);
    case (mode)
      2'b00:   return acc;
      2'b01:   return ~acc;
      2'b10:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    len_clamped = DATA_LEN;
    if (DATA_LEN < MIN_LEN) begin
      len_clamped = MIN_LEN;
    end else if (DATA_LEN > MAX_LEN) begin
      len_clamped = MAX_LEN;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg    <= IDLE;
      acc_reg      <= 1'b0;
      cnt_reg      <= '0;
      len_reg      <= MIN_LEN;
      dir_rx_reg   <= 1'b0;
      par_en_reg   <= 1'b0;
      par_mode_reg <= 2'b00;
      par_bit_reg  <= 1'b0;
      mis_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      acc_reg      <= acc_next;
      cnt_reg      <= cnt_next;
      len_reg      <= len_next;
      dir_rx_reg   <= dir_rx_next;
      par_en_reg   <= par_en_next;
      par_mode_reg <= par_mode_next;
      par_bit_reg  <= par_bit_next;
      mis_reg      <= mis_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    acc_next      = acc_reg;
    cnt_next      = cnt_reg;
    len_next      = len_reg;
    dir_rx_next   = dir_rx_reg;
    par_en_next   = par_en_reg;
    par_mode_next = par_mode_reg;
    par_bit_next  = par_bit_reg;
    mis_next      = mis_reg;

    // A new frame overrides whatever is in flight, including a coincident data bit.
    if (FRAME_START) begin
      state_next    = DATA;
      acc_next      = 1'b0;
      cnt_next      = '0;
      len_next      = len_clamped;
      dir_rx_next   = DIR_RX;
      par_en_next   = PAR_EN;
      par_mode_next = PAR_MODE;
      mis_next      = 1'b0;
    end else begin
      case (state_reg)
        DATA: begin
          if (BIT_VALID) begin
            acc_next = acc_reg ^ BIT_IN;
            cnt_next = cnt_reg + LEN_WIDTH'(1);
            if (cnt_next == len_reg) begin
              if (par_en_reg) begin
                par_bit_next = parity_of(par_mode_reg, acc_next);
              end
              state_next = (dir_rx_reg && par_en_reg) ? PARITY : DONE;
            end
          end
        end
        PARITY: begin
          if (BIT_VALID) begin
            mis_next   = BIT_IN ^ par_bit_reg;
            state_next = DONE;
          end
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Pulses decode the registered DONE state so they still fire if a new frame starts then.
  assign done       = (state_reg == DONE);
  assign FRAME_DONE = done;
  assign PAR_RDY    = done && !dir_rx_reg && par_en_reg;
  assign PAR_ERR    = done && mis_reg;
  assign PAR_BIT    = par_bit_reg;
  assign BUSY       = (state_reg != IDLE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      err_cnt_reg <= '0;
    end else if (CNT_CLR) begin
      err_cnt_reg <= '0;
    end else if (PAR_ERR && (err_cnt_reg != CNT_MAX)) begin
      err_cnt_reg <= err_cnt_reg + CNT_WIDTH'(1);
    end
  end

  assign ERR_CNT = err_cnt_reg;

endmodule

// File: tb/tb_uart_par_engine.sv
// Directed bench for uart_par_engine: stimulus queues expected frame results,
// a negedge monitor pops and checks them whenever FRAME_DONE is seen.
module tb_uart_par_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_start = 1'b0;
  logic       dir_rx = 1'b0;
  logic       par_en = 1'b0;
  logic [1:0] par_mode = 2'b00;
  logic [4:0] data_len = 5'd8;
  logic       bit_valid = 1'b0;
  logic       bit_in = 1'b0;
  logic       cnt_clr = 1'b0;
  logic       par_bit, par_rdy, par_err, frame_done, busy;
  logic [1:0] err_cnt;

  int checks = 0;
  int errors = 0;
  int fid = 0;

  typedef struct {
    int         id;
    logic       rdy;
    logic       err;
    logic       pbit;
    logic [1:0] cnt;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  logic       cnt_pending = 1'b0;
  logic [1:0] cnt_exp = 2'd0;
  int         cnt_id = 0;

  uart_par_engine #(.MAX_WIDTH(9), .CNT_WIDTH(2), .LEN_WIDTH(5)) dut (
    .CLK(clk), .RST(rst), .FRAME_START(frame_start), .DIR_RX(dir_rx),
    .PAR_EN(par_en), .PAR_MODE(par_mode), .DATA_LEN(data_len),
    .BIT_VALID(bit_valid), .BIT_IN(bit_in), .CNT_CLR(cnt_clr),
    .PAR_BIT(par_bit), .PAR_RDY(par_rdy), .PAR_ERR(par_err),
    .FRAME_DONE(frame_done), .BUSY(busy), .ERR_CNT(err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  // Monitor: one line per completed frame, compared against the queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      cnt_pending = 1'b0;
    end else begin
      if (cnt_pending) begin
        checks++;
        if (err_cnt !== cnt_exp) begin
          errors++;
          $display("FAIL err_cnt frame %0d: got %0d expected %0d", cnt_id, err_cnt, cnt_exp);
        end
        cnt_pending = 1'b0;
      end
      if (frame_done) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_frame_done: got done=1 expected no frame");
        end else begin
          e = exp_q.pop_front();
          $display("frame %0d done: rdy=%0b err=%0b bit=%0b", e.id, par_rdy, par_err, par_bit);
          if (par_rdy !== e.rdy) begin
            errors++;
            $display("FAIL par_rdy frame %0d: got %0b expected %0b", e.id, par_rdy, e.rdy);
          end
          checks++;
          if (par_err !== e.err) begin
            errors++;
            $display("FAIL par_err frame %0d: got %0b expected %0b", e.id, par_err, e.err);
          end
          checks++;
          if (par_bit !== e.pbit) begin
            errors++;
            $display("FAIL par_bit frame %0d: got %0b expected %0b", e.id, par_bit, e.pbit);
          end
          cnt_exp     = e.cnt;
          cnt_id      = e.id;
          cnt_pending = 1'b1;
        end
      end else if (par_rdy || par_err) begin
        checks++;
        errors++;
        $display("FAIL stray_pulse: got rdy=%0b err=%0b expected both 0 outside FRAME_DONE",
                 par_rdy, par_err);
      end
    end
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic step(input logic fs, input logic bv, input logic bi, input logic clr);
    frame_start = fs;
    bit_valid   = bv;
    bit_in      = bi;
    cnt_clr     = clr;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    bit_valid   = 1'b0;
    bit_in      = 1'b0;
    cnt_clr     = 1'b0;
  endtask

  task automatic start(input logic rx, input logic pen, input logic [1:0] mode,
                       input logic [4:0] len, input logic bv, input logic bi);
    dir_rx   = rx;
    par_en   = pen;
    par_mode = mode;
    data_len = len;
    step(1'b1, bv, bi, 1'b0);
  endtask

  task automatic send(input logic [15:0] d, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, d[i], 1'b0);
  endtask

  task automatic expect_frame(input logic rdy, input logic err, input logic pbit,
                              input logic [1:0] cnt);
    fid++;
    exp_q.push_back('{id: fid, rdy: rdy, err: err, pbit: pbit, cnt: cnt});
  endtask

  task automatic tx_frame(input logic pen, input logic [1:0] mode, input logic [4:0] len,
                          input logic [15:0] d, input int n);
    start(1'b0, pen, mode, len, 1'b0, 1'b0);
    send(d, n);
    chk1("tx_latency_done", frame_done, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rx_frame(input logic [1:0] mode, input logic [4:0] len, input logic [15:0] d,
                          input int n, input logic pbit_rx, input logic clr);
    start(1'b1, 1'b1, mode, len, 1'b0, 1'b0);
    send(d, n);
    chk1("rx_wait_parity", frame_done, 1'b0);
    step(1'b0, 1'b1, pbit_rx, 1'b0);
    chk1("rx_latency_done", frame_done, 1'b1);
    step(1'b0, 1'b0, 1'b0, clr);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk1("reset_par_bit", par_bit, 1'b0);
    chk1("reset_par_rdy", par_rdy, 1'b0);
    chk1("reset_par_err", par_err, 1'b0);
    chk1("reset_frame_done", frame_done, 1'b0);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_err_cnt_zero", err_cnt == 2'd0, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // TX even, 0xA5 (four ones) -> 0, with busy/latency checks.
    expect_frame(1'b1, 1'b0, 1'b0, 2'd0);
    start(1'b0, 1'b1, 2'b00, 5'd8, 1'b0, 1'b0);
    chk1("busy_rise", busy, 1'b1);
    send(16'h00A5, 8);
    chk1("tx_latency_done", frame_done, 1'b1);
    chk1("tx_latency_rdy", par_rdy, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk1("busy_fall", busy, 1'b0);

    // TX odd, same data -> 1.
    expect_frame(1'b1, 1'b0, 1'b1, 2'd0);
    tx_frame(1'b1, 2'b01, 5'd8, 16'h00A5, 8);

    // RX odd, 7 bits of 0x45 (three ones) -> expected parity 0.
    expect_frame(1'b0, 1'b0, 1'b0, 2'd0);
    rx_frame(2'b01, 5'd7, 16'h0045, 7, 1'b0, 1'b0);
    expect_frame(1'b0, 1'b1, 1'b0, 2'd1);
    rx_frame(2'b01, 5'd7, 16'h0045, 7, 1'b1, 1'b0);

    // RX mark, received 0 -> error.
    expect_frame(1'b0, 1'b1, 1'b1, 2'd2);
    rx_frame(2'b10, 5'd5, 16'h001F, 5, 1'b0, 1'b0);

    // No parity, length 3 clamps to 5; PAR_BIT keeps the previous 1.
    expect_frame(1'b0, 1'b0, 1'b1, 2'd2);
    start(1'b0, 1'b0, 2'b00, 5'd3, 1'b0, 1'b0);
    send(16'h0000, 4);
    chk1("clamp_not_done_4", frame_done, 1'b0);
    send(16'h0000, 1);
    chk1("clamp_done_5", frame_done, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // TX space on all-ones data -> 0.
    expect_frame(1'b1, 1'b0, 1'b0, 2'd2);
    tx_frame(1'b1, 2'b11, 5'd8, 16'h00FF, 8);

    // Abort after 4 bits; restart coincides with a dropped '1' bit; 0x01 even -> 1.
    start(1'b0, 1'b1, 2'b00, 5'd8, 1'b0, 1'b0);
    send(16'h0007, 4);
    expect_frame(1'b1, 1'b0, 1'b1, 2'd2);
    start(1'b0, 1'b1, 2'b00, 5'd8, 1'b1, 1'b1);
    send(16'h0001, 7);
    chk1("dropped_bit_not_done", frame_done, 1'b0);
    send(16'h0000, 1);
    chk1("restart_done", frame_done, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back: second FRAME_START lands in the first frame's DONE cycle.
    expect_frame(1'b1, 1'b0, 1'b0, 2'd2);
    start(1'b0, 1'b1, 2'b00, 5'd5, 1'b0, 1'b0);
    send(16'h0000, 5);
    expect_frame(1'b1, 1'b0, 1'b1, 2'd2);
    start(1'b0, 1'b1, 2'b01, 5'd5, 1'b0, 1'b0);
    chk1("b2b_busy", busy, 1'b1);
    send(16'h0000, 5);
    chk1("b2b_done", frame_done, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Three more bad RX frames: counter saturates at 3.
    for (int k = 0; k < 3; k++) begin
      expect_frame(1'b0, 1'b1, 1'b1, 2'd3);
      rx_frame(2'b00, 5'd5, 16'h0001, 5, 1'b0, 1'b0);
    end

    // Clear coinciding with an increment wins; the next error counts from 0.
    expect_frame(1'b0, 1'b1, 1'b1, 2'd0);
    rx_frame(2'b00, 5'd5, 16'h0001, 5, 1'b0, 1'b1);
    expect_frame(1'b0, 1'b1, 1'b1, 2'd1);
    rx_frame(2'b00, 5'd5, 16'h0001, 5, 1'b0, 1'b0);

    // Asynchronous reset mid-frame, checked between clock edges.
    start(1'b1, 1'b1, 2'b00, 5'd8, 1'b0, 1'b0);
    send(16'h0003, 3);
    rst = 1'b0;
    #1;
    chk1("async_busy", busy, 1'b0);
    chk1("async_par_bit", par_bit, 1'b0);
    chk1("async_err_cnt_zero", err_cnt == 2'd0, 1'b1);
    chk1("async_frame_done", frame_done, 1'b0);
    chk1("async_par_err", par_err, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    expect_frame(1'b1, 1'b0, 1'b0, 2'd0);
    tx_frame(1'b1, 2'b00, 5'd8, 16'h00A5, 8);

    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_frames: got %0d frames outstanding expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
